// File: rtl/bcd_scan_display_if.sv
// Display-side bundle for bcd_scan_display: snapshot/load inputs and the
// registered segment/anode scan outputs.
interface bcd_scan_display_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  blank_lz;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic [2:0]            digit_idx;
  logic                  frame_done;

  modport master (
    output load, bcd_in, blank_lz,
    input  seg, an, digit_idx, frame_done
  );

  modport slave (
    input  load, bcd_in, blank_lz,
    output seg, an, digit_idx, frame_done
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver for a BCD counter chain,
// with snapshot on load, inter-digit blanking gap and leading-zero blanking.
//
// state | meaning
// SHOW  | current digit anode on, segments decoded from snapshot
// GAP   | all anodes off; index advances on the last gap cycle
module bcd_scan_display #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1000,
  parameter int GAP_CYCLES     = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_scan_display_if.slave bus
);

  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

  localparam int MAXC = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]     SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [2:0]          idx, idx_nx;
  logic                wrap;
  logic [4*DIGITS-1:0] snap;

  logic [3:0]          cur_code;
  logic                cur_blank;
  logic [DIGITS-1:0]   zero_from;
  logic [6:0]          seg_lit, seg_d;
  logic [DIGITS-1:0]   an_on, an_d;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SHOW;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Snapshot is independent of the scan timing so a load never shifts on-time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      snap <= '0;
    else if (bus.load)
      snap <= bus.bcd_in;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    wrap     = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nx   = '0;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = SHOW;
          if (idx == IDX_LAST) begin
            idx_nx = '0;
            wrap   = 1'b1;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      default: state_nx = SHOW;
    endcase
  end

  // zero_from[i]: digits i..DIGITS-1 all zero; invalid codes count as non-zero.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (snap[4*i +: 4] == 4'd0);
      zero_from[i] = acc;
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_blank = 1'b0;
    an_on     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur_code  = snap[4*i +: 4];
        cur_blank = (i != 0) && zero_from[i];
        an_on[i]  = 1'b1;
      end
    end
    if (state == SHOW) begin
      seg_lit = (bus.blank_lz && cur_blank) ? 7'h00 : decode(cur_code);
    end else begin
      seg_lit = 7'h00;
      an_on   = '0;
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    an_d  = AN_ACTIVE_LOW ? ~an_on : an_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg        <= SEG_OFF;
      bus.an         <= AN_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg        <= seg_d;
      bus.an         <= an_d;
      bus.frame_done <= wrap;
    end
  end

  assign bus.digit_idx = idx;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display (DIGITS=4, PRESCALE=4, GAP_CYCLES=1,
// active-low segments and anodes): expected per-cycle outputs are queued by the stimulus.
module tb_bcd_scan_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_scan_display_if #(.DIGITS(4)) bus ();

  bcd_scan_display #(
    .DIGITS(4), .PRESCALE(4), .GAP_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] idx;
    logic       fd;
  } obs_t;

  obs_t  expq[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    cyc     = 0;
  string label   = "reset";

  function automatic obs_t mk(logic [6:0] s, logic [3:0] a, logic [2:0] i, logic f);
    obs_t o;
    o.seg = s; o.an = a; o.idx = i; o.fd = f;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(bus.seg, bus.an, bus.digit_idx, bus.frame_done);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got seg=%h an=%b idx=%0d fd=%b, required seg=%h an=%b idx=%0d fd=%b",
               name, got.seg, got.an, got.idx, got.fd, exp.seg, exp.an, exp.idx, exp.fd);
  endtask

  // Monitor: compares one queued expectation per cycle, away from the active edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check($sformatf("%s_cyc%0d", label, cyc), observe(), e);
      end
    end
  end

  // One digit slot: 4 on-cycles, then the gap cycle, during which the index
  // has already advanced and frame_done marks the wrap after digit 3.
  task automatic push_on(input int k, input logic [6:0] s);
    expq.push_back(mk(s, ~(4'b0001 << k), 3'(k), 1'b0));
  endtask

  task automatic push_gap(input int k);
    expq.push_back(mk(7'h7F, 4'hF, 3'((k + 1) % 4), k == 3));
  endtask

  task automatic push_slot(input int k, input logic [6:0] s);
    for (int j = 0; j < 4; j++) push_on(k, s);
    push_gap(k);
  endtask

  // Called just after a sample; edge 1 of the frame is the next rising edge.
  // load_cyc=c applies load/bcd_in/blank_lz on edge c of the frame.
  task automatic run_frame(input logic [6:0] s0, s1, s2, s3, input bit push,
                           input int ncyc, input int load_cyc,
                           input logic [15:0] nxt, input logic nblank);
    if (push) begin
      push_slot(0, s0); push_slot(1, s1); push_slot(2, s2); push_slot(3, s3);
    end
    for (int c = 1; c <= ncyc; c++) begin
      if (c == load_cyc) begin
        bus.load     = 1'b1;
        bus.bcd_in   = nxt;
        bus.blank_lz = nblank;
      end
      @(negedge clk);
      #1;
      if (bus.load) begin
        bus.load   = 1'b0;
        bus.bcd_in = ~nxt;
      end
    end
  endtask

  initial begin
    bus.load     = 1'b0;
    bus.bcd_in   = 16'h0000;
    bus.blank_lz = 1'b0;

    expq.push_back(mk(7'h7F, 4'hF, 3'd0, 1'b0));
    @(negedge clk);
    #1;
    rst = 1'b0;

    label = "zero";
    run_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b1, 20, 20, 16'h1234, 1'b0);
    label = "d1234";
    run_frame(7'h19, 7'h30, 7'h24, 7'h79, 1'b1, 20, 20, 16'h0050, 1'b1);
    label = "d0050_blank";
    run_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 1'b1, 20, 20, 16'h0050, 1'b0);
    label = "d0050_noblank";
    run_frame(7'h40, 7'h12, 7'h40, 7'h40, 1'b1, 20, 20, 16'h0A00, 1'b1);
    label = "d0A00_blank";
    run_frame(7'h40, 7'h40, 7'h3F, 7'h7F, 1'b1, 20, 20, 16'h0A00, 1'b0);

    // Load 9999 on edge 12: digit 2 is mid on-time; seg changes one cycle later.
    label = "midload";
    push_slot(0, 7'h40);
    push_slot(1, 7'h40);
    push_on(2, 7'h3F); push_on(2, 7'h3F); push_on(2, 7'h10); push_on(2, 7'h10);
    push_gap(2);
    push_slot(3, 7'h10);
    run_frame(7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 20, 12, 16'h9999, 1'b0);

    // Run into the gap state of digit 3, then reset asynchronously.
    label = "prereset";
    push_slot(0, 7'h10); push_slot(1, 7'h10); push_slot(2, 7'h10);
    for (int j = 0; j < 4; j++) push_on(3, 7'h10);
    run_frame(7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 19, 0, 16'h0000, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async", observe(), mk(7'h7F, 4'hF, 3'd0, 1'b0));
    label = "inreset";
    expq.push_back(mk(7'h7F, 4'hF, 3'd0, 1'b0));
    @(negedge clk);
    #1;
    rst = 1'b0;

    label = "postreset";
    run_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b1, 20, 0, 16'h0000, 1'b0);

    n_total++;
    if (expq.size() == 0)
      n_pass++;
    else
      $display("FAIL queue_drained: got %0d pending entries, required 0", expq.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
